mfe_img_loader: RTL and testbench

- Upstream stage of the median filter engine (MFE).
- Accepts a raster-order 8-bit grayscale pixel stream over a valid/ready handshake and writes one 128x128 frame into the grayscale image memory.
- Once the frame is complete, it hands the memory to the MFE via `mfe_ready` and tracks `mfe_busy` until filtering finishes.
- Then it reports frame completion and accepts the next frame; the image memory is never written while the MFE owns it.

---
 rtl/mfe_pkg.sv | 34 +++
 rtl/mfe_ldr_wr_port.sv | 77 +++++++
 rtl/mfe_img_loader.sv | 143 ++++++++++++++
 tb/tb_mfe_img_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfe_pkg.sv
`default_nettype none
// ============================================================================
// mfe_pkg -- shared median-filter-engine geometry and state encodings
// Rev 1.0
// ============================================================================
package mfe_pkg;

    localparam int MFE_IMG_W   = 128;
    localparam int MFE_IMG_H   = 128;
    localparam int MFE_AW      = 14;
    localparam int MFE_DW      = 8;
    localparam int MFE_CKSUM_W = 16;

    typedef enum logic [2:0] {
        LDR_IDLE    = 3'd0,
        LDR_LOAD    = 3'd1,
        LDR_KICK    = 3'd2,
        LDR_WAIT_LO = 3'd3,
        LDR_DONE    = 3'd4
    } ldr_state_e;

    // Filter-side states, kept here so loader and filter agree on geometry
    typedef enum logic [1:0] {
        MFE_ST_IDLE  = 2'd0,
        MFE_ST_RUN   = 2'd1,
        MFE_ST_FLUSH = 2'd2
    } mfe_state_e;

    function automatic int unsigned mfe_npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mfe_ldr_wr_port.sv
`default_nettype none
// ============================================================================
// mfe_ldr_wr_port -- registered image-memory write stage (+ optional checksum
// accumulator under MFE_LDR_CKSUM_EN).  Rev 1.0
// ============================================================================
module mfe_ldr_wr_port
    import mfe_pkg::*;
#(
    parameter int AW = MFE_AW,
    parameter int DW = MFE_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sof,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_we,
    output logic [MFE_CKSUM_W-1:0] cksum
);

    logic          mem_we_d,    mem_we_q;
    logic [AW-1:0] mem_addr_d,  mem_addr_q;
    logic [DW-1:0] mem_wdata_d, mem_wdata_q;

    always_comb begin
        mem_we_d    = wr_en;
        mem_addr_d  = wr_en ? wr_addr : mem_addr_q;
        mem_wdata_d = wr_en ? wr_data : mem_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MFE_LDR_CKSUM_EN
    logic [MFE_CKSUM_W-1:0] cksum_d, cksum_q;

    // An s_sof beat restarts the sum with its own pixel
    always_comb begin
        cksum_d = cksum_q;
        if (wr_en) begin
            cksum_d = (wr_sof ? '0 : cksum_q) + MFE_CKSUM_W'(wr_data);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    logic unused_sof;
    assign unused_sof = wr_sof;
    assign cksum      = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/mfe_img_loader.sv
`default_nettype none
// ============================================================================
// mfe_img_loader -- loads one raster frame into image memory, then hands it to
// the MFE.  Optional checksum: define MFE_LDR_CKSUM_EN.  Rev 1.0
// ============================================================================
module mfe_img_loader
    import mfe_pkg::*;
#(
    parameter int IMG_W = MFE_IMG_W,
    parameter int IMG_H = MFE_IMG_H,
    parameter int AW    = MFE_AW,
    parameter int DW    = MFE_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_sof,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic                   mem_we,
    output logic                   mfe_ready,
    input  logic                   mfe_busy,
    output logic                   frame_done,
    output logic                   err_sof,
    output logic [MFE_CKSUM_W-1:0] cksum
);

    localparam logic [AW:0] CNT_LAST = (AW+1)'(mfe_npix(IMG_W, IMG_H) - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    ldr_state_e  state_d, state_q;
    logic [AW:0] cnt_d, cnt_q;
    logic        s_ready_d, s_ready_q;
    logic        mfe_ready_d, mfe_ready_q;
    logic        frame_done_d, frame_done_q;
    logic        err_sof_d, err_sof_q;

    logic          accept;
    logic          wr_en;
    logic          wr_sof;
    logic [AW-1:0] wr_addr;

    assign accept = s_valid && s_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_sof    = 1'b0;
        wr_addr   = '0;
        err_sof_d = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (accept && s_sof) begin
                    wr_en   = 1'b1;
                    wr_sof  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_sof) begin
                        wr_sof    = 1'b1;
                        err_sof_d = 1'b1;
                        cnt_d     = CNT_ONE;
                    end else begin
                        wr_addr = cnt_q[AW-1:0];
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d = LDR_KICK;
                        end
                    end
                end
            end
            LDR_KICK: begin
                if (mfe_busy) begin
                    state_d = LDR_WAIT_LO;
                end
            end
            LDR_WAIT_LO: begin
                if (!mfe_busy) begin
                    state_d = LDR_DONE;
                end
            end
            LDR_DONE: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register together with it
        s_ready_d    = (state_d == LDR_IDLE) || (state_d == LDR_LOAD);
        mfe_ready_d  = (state_d == LDR_KICK);
        frame_done_d = (state_d == LDR_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LDR_IDLE;
            cnt_q        <= '0;
            s_ready_q    <= 1'b0;
            mfe_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            mfe_ready_q  <= mfe_ready_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mfe_ready  = mfe_ready_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

    mfe_ldr_wr_port #(
        .AW (AW),
        .DW (DW)
    ) u_wr_port (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sof    (wr_sof),
        .wr_addr   (wr_addr),
        .wr_data   (s_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cksum     (cksum)
    );

endmodule
`default_nettype wire

// File: tb/tb_mfe_img_loader.sv
`default_nettype none
// ============================================================================
// tb_mfe_img_loader -- directed self-checking bench for mfe_img_loader
// Rev 1.0
// ============================================================================
module tb_mfe_img_loader;

    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int NPIX = 16384;
`ifdef MFE_LDR_CKSUM_EN
    localparam logic [15:0] CK_PATTERN = 16'hE000;
    localparam logic [15:0] CK_ALL_FF  = 16'hC000;
`else
    localparam logic [15:0] CK_PATTERN = 16'h0000;
    localparam logic [15:0] CK_ALL_FF  = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_sof = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mfe_ready;
    logic          mfe_busy = 1'b0;
    logic          frame_done;
    logic          err_sof;
    logic [15:0]   cksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] act_addr[$];
    logic [DW-1:0] act_data[$];
    int we_total  = 0;
    int err_cnt   = 0;
    int done_cnt  = 0;

    always #5 clk = ~clk;

    mfe_img_loader dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mfe_ready  (mfe_ready),
        .mfe_busy   (mfe_busy),
        .frame_done (frame_done),
        .err_sof    (err_sof),
        .cksum      (cksum)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            act_addr.push_back(mem_addr);
            act_data.push_back(mem_wdata);
            we_total++;
        end
        if (err_sof)    err_cnt++;
        if (frame_done) done_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [DW-1:0] d, input logic sof);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        mfe_busy = 1'b1;
        @(negedge clk);
        mfe_busy = 1'b0;
        while (!frame_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_done_timeout"}, n, 0);
        @(negedge clk);
    endtask

    // restart_at > 0: writes 0..restart_at-1 precede a restart at address 0
    task automatic cmp_frame(input string tag, input int n_exp, input int restart_at, input logic all_ff);
        int bad = 0;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        chk({tag, "_wr_count"}, act_addr.size(), n_exp);
        for (int k = 0; k < act_addr.size() && k < n_exp; k++) begin
            ea = (k < restart_at) ? AW'(k) : AW'(k - restart_at);
            ed = all_ff ? 8'hFF : ea[7:0];
            if (act_addr[k] !== ea || act_data[k] !== ed) bad++;
        end
        chk({tag, "_wr_errors"}, bad, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"},    s_ready,    0);
        chk({tag, "_mem_we"},     mem_we,     0);
        chk({tag, "_mem_addr"},   mem_addr,   0);
        chk({tag, "_mem_wdata"},  mem_wdata,  0);
        chk({tag, "_mfe_ready"},  mfe_ready,  0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_sof"},    err_sof,    0);
        chk({tag, "_cksum"},      cksum,      0);
    endtask

    initial begin
        int rdy_cnt, we_snap, done_snap, idle_we, rdy_drop;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready_up", s_ready, 1);

        // ---------------- frame 1: back-to-back, pixel = addr[7:0] ----------------
        act_addr.delete();
        act_data.delete();
        for (int i = 0; i < NPIX; i++) begin
            if (i == NPIX - 1) chk("f1_mfe_ready_pre", mfe_ready, 0);
            send(DW'(i), i == 0);
        end
        chk("f1_mfe_ready",    mfe_ready, 1);
        chk("f1_s_ready_drop", s_ready,   0);
        chk("f1_last_we",      mem_we,    1);
        chk("f1_last_addr",    mem_addr,  NPIX - 1);
        chk("f1_last_data",    mem_wdata, 8'hFF);
        chk("f1_cksum",        cksum,     CK_PATTERN);

        // MFE handshake: busy low 5 cycles, high 100, then low
        done_snap = done_cnt;
        rdy_cnt   = 0;
        for (int k = 0; k < 5; k++) begin
            if (mfe_ready) rdy_cnt++;
            @(negedge clk);
        end
        we_snap  = we_total;
        mfe_busy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (mfe_ready) rdy_cnt++;
            @(negedge clk);
        end
        chk("hs_ready_cycles", rdy_cnt, 6);
        mfe_busy = 1'b0;
        chk("hs_done_pre", frame_done, 0);
        @(negedge clk);
        chk("hs_done_pulse",    frame_done, 1);
        chk("hs_s_ready_done",  s_ready,    0);
        @(negedge clk);
        chk("hs_done_clr",      frame_done, 0);
        chk("hs_s_ready_idle",  s_ready,    1);
        chk("hs_done_count",    done_cnt - done_snap, 1);
        chk("hs_no_write",      we_total - we_snap,   0);
        chk("hs_cksum_stable",  cksum, CK_PATTERN);
        cmp_frame("f1", NPIX, 0, 1'b0);

        // ---------------- frame 2: s_valid toggling ----------------
        act_addr.delete();
        act_data.delete();
        idle_we  = 0;
        rdy_drop = 0;
        for (int i = 0; i < NPIX; i++) begin
            send(DW'(i), i == 0);
            if (i != NPIX - 1) begin
                @(negedge clk);
                if (mem_we)   idle_we++;
                if (!s_ready) rdy_drop++;
            end
        end
        chk("f2_mfe_ready",   mfe_ready, 1);
        chk("f2_idle_writes", idle_we,   0);
        chk("f2_ready_drops", rdy_drop,  0);
        finish_frame("f2");
        cmp_frame("f2", NPIX, 0, 1'b0);

        // ---------------- frame 3: junk in IDLE, restart at pixel 500, all 0xFF ----------------
        act_addr.delete();
        act_data.delete();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        @(negedge clk);
        chk("f3_junk_dropped", act_addr.size(), 0);
        for (int i = 0; i < 500; i++) send(8'hFF, i == 0);
        chk("f3_err_pre", err_cnt, 0);
        send(8'hFF, 1'b1);
        chk("f3_err_pulse",    err_sof,  1);
        chk("f3_restart_we",   mem_we,   1);
        chk("f3_restart_addr", mem_addr, 0);
        @(negedge clk);
        chk("f3_err_clr", err_sof, 0);
        for (int i = 1; i < NPIX; i++) begin
            if (i == NPIX - 1) chk("f3_mfe_ready_pre", mfe_ready, 0);
            send(8'hFF, 1'b0);
        end
        chk("f3_mfe_ready", mfe_ready, 1);
        chk("f3_cksum",     cksum,     CK_ALL_FF);
        chk("f3_err_count", err_cnt,   1);
        finish_frame("f3");
        chk("f3_cksum_stable", cksum, CK_ALL_FF);
        cmp_frame("f3", 500 + NPIX, 500, 1'b1);
        chk("f3_first_addr", act_addr[0], 0);

        // ---------------- frame 4: reset mid-load at pixel 1000 ----------------
        for (int i = 0; i < 1000; i++) send(DW'(i), i == 0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        we_snap = we_total;
        send(8'h55, 1'b0);
        @(negedge clk);
        chk("post_rst_idle_drop", we_total - we_snap, 0);
        chk("post_rst_mfe_ready", mfe_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
